// File: rtl/cellift_taint_mem_resp.sv
// ---------------------------------------------------------------------------
// cellift_taint_mem_resp
//
// Single-port word memory with a shadow taint array tracking information
// flow. After reset an INIT sweep clears every taint word (one per cycle);
// the data array is never cleared. Once READY, requests are granted in the
// same cycle and answered one cycle later on rvalid_o, for reads and writes.
//
// Optional feature (macro CELLIFT_MEM_TAINT_INJECT_EN): adds a taint
// injection port that ORs a mask into one taint word per cycle while READY.
//
// Ports
//   clk_i, rst_i          clock, asynchronous active-high reset
//   req_i / gnt_o         request and same-cycle grant (grant only in READY)
//   addr_i, we_i          word address (wraps modulo Depth), write enable
//   wdata_i, strb_i       write data and per-bit write strobe
//   rvalid_o, rdata_o     response valid pulse and read data
//   *_t0_i                taint of the corresponding request inputs
//   rdata_t0_o            taint of rdata_o
//   init_done_o           high once the taint array has been cleared
//   inj_valid_i, inj_addr_i, inj_mask_i   (macro only) taint injection
// ---------------------------------------------------------------------------
module cellift_taint_mem_resp #(
    parameter int Depth = 1 << 15,
    parameter int Aw    = $clog2(Depth)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          req_i,
    output logic          gnt_o,
    input  logic [Aw-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    input  logic [31:0]   strb_i,
    input  logic          we_i,
    output logic          rvalid_o,
    output logic [31:0]   rdata_o,
    input  logic          req_t0_i,
    input  logic [Aw-1:0] addr_t0_i,
    input  logic [31:0]   wdata_t0_i,
    input  logic [31:0]   strb_t0_i,
    input  logic          we_t0_i,
    output logic [31:0]   rdata_t0_o,
`ifdef CELLIFT_MEM_TAINT_INJECT_EN
    input  logic          inj_valid_i,
    input  logic [Aw-1:0] inj_addr_i,
    input  logic [31:0]   inj_mask_i,
`endif
    output logic          init_done_o
);

    typedef enum logic [0:0] {
        StInit  = 1'b0,
        StReady = 1'b1
    } state_e;

    localparam logic [Aw:0]   DepthW   = (Aw + 1)'(Depth);
    localparam logic [Aw-1:0] LastAddr = Aw'(Depth - 1);

    // Reduce an address into 0..Depth-1. An Aw-bit value is always below
    // 2*Depth, so one conditional subtraction is enough.
    function automatic logic [Aw-1:0] wrap_addr(input logic [Aw-1:0] a);
        logic [Aw:0] ext;
        ext = {1'b0, a};
        ext = (ext >= DepthW) ? (ext - DepthW) : ext;
        return ext[Aw-1:0];
    endfunction

    // Storage: neither array has a reset; the taint array is cleared by the
    // INIT sweep instead.
    logic [31:0] data_mem_q  [Depth];
    logic [31:0] taint_mem_q [Depth];

    state_e        state_q, state_d;
    logic [Aw-1:0] cnt_q, cnt_d;
    logic          rvalid_q, rvalid_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [31:0]   rdata_t0_q, rdata_t0_d;

    logic          gnt_s;
    logic          wr_en_s;
    logic          rd_en_s;
    logic [Aw-1:0] addr_w_s;
    logic          ctrl_taint_s;
    logic          wr_all_taint_s;
    logic [31:0]   data_wr_word_s;
    logic [31:0]   taint_wr_word_s;
    logic          inj_same_s;

`ifdef CELLIFT_MEM_TAINT_INJECT_EN
    logic          inj_en_s;
    logic [Aw-1:0] inj_addr_w_s;
`endif

    // Request decode, write-word merge and optional injection qualification.
    always_comb begin
        gnt_s           = 1'b0;
        wr_en_s         = 1'b0;
        rd_en_s         = 1'b0;
        addr_w_s        = wrap_addr(addr_i);
        // Tainted control (address or request) makes the whole access tainted.
        ctrl_taint_s    = (|addr_t0_i) | req_t0_i;
        wr_all_taint_s  = ctrl_taint_s | we_t0_i;
        inj_same_s      = 1'b0;

        if (state_q == StReady) begin
            gnt_s = req_i;
        end else begin
            gnt_s = 1'b0;
        end

        wr_en_s = gnt_s & we_i;
        rd_en_s = gnt_s & ~we_i;

        data_wr_word_s  = (data_mem_q[addr_w_s] & ~strb_i) | (wdata_i & strb_i);

        if (wr_all_taint_s) begin
            taint_wr_word_s = 32'hFFFF_FFFF;
        end else begin
            taint_wr_word_s = (taint_mem_q[addr_w_s] & ~strb_i)
                            | (wdata_t0_i & strb_i)
                            | strb_t0_i;
        end

`ifdef CELLIFT_MEM_TAINT_INJECT_EN
        inj_en_s     = inj_valid_i & (state_q == StReady);
        inj_addr_w_s = wrap_addr(inj_addr_i);
        inj_same_s   = inj_en_s & wr_en_s & (inj_addr_w_s == addr_w_s);
        // Same-word collision: the write lands first, the mask is ORed on top.
        if (inj_same_s) begin
            taint_wr_word_s = taint_wr_word_s | inj_mask_i;
        end else begin
            taint_wr_word_s = taint_wr_word_s;
        end
`endif
    end

    // Next-state logic for the INIT/READY FSM, sweep counter and response.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rvalid_d   = gnt_s;
        rdata_d    = rdata_q;
        rdata_t0_d = rdata_t0_q;

        case (state_q)
            StInit: begin
                if (cnt_q == LastAddr) begin
                    state_d = StReady;
                    cnt_d   = cnt_q;
                end else begin
                    state_d = StInit;
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            StReady: begin
                state_d = StReady;
                cnt_d   = cnt_q;
            end
            default: begin
                state_d = StInit;
                cnt_d   = '0;
            end
        endcase

        // Writes leave the read-data registers untouched.
        if (rd_en_s) begin
            rdata_d    = data_mem_q[addr_w_s];
            rdata_t0_d = taint_mem_q[addr_w_s] | {32{ctrl_taint_s}};
        end else begin
            rdata_d    = rdata_q;
            rdata_t0_d = rdata_t0_q;
        end
    end

    // State, sweep counter and response registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= StInit;
            cnt_q      <= '0;
            rvalid_q   <= 1'b0;
            rdata_q    <= 32'h0;
            rdata_t0_q <= 32'h0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rdata_t0_q <= rdata_t0_d;
        end
    end

    // Data array write port (strobe merge computed above).
    always_ff @(posedge clk_i) begin
        if (wr_en_s) begin
            data_mem_q[addr_w_s] <= data_wr_word_s;
        end
    end

    // Taint array: INIT sweep clear, granted writes, and optional injection.
    always_ff @(posedge clk_i) begin
        if (state_q == StInit) begin
            taint_mem_q[cnt_q] <= 32'h0;
        end else begin
            if (wr_en_s) begin
                taint_mem_q[addr_w_s] <= taint_wr_word_s;
            end
`ifdef CELLIFT_MEM_TAINT_INJECT_EN
            // A colliding injection is already folded into the write word.
            if (inj_en_s && !inj_same_s) begin
                taint_mem_q[inj_addr_w_s] <= taint_mem_q[inj_addr_w_s] | inj_mask_i;
            end
`endif
        end
    end

    assign gnt_o       = gnt_s;
    assign rvalid_o    = rvalid_q;
    assign rdata_o     = rdata_q;
    assign rdata_t0_o  = rdata_t0_q;
    assign init_done_o = (state_q == StReady);

endmodule

// File: doc/cellift_taint_mem_resp.md
CELLIFT_TAINT_MEM_RESP -- requirements
Module: cellift_taint_mem_resp

Interface
REQ-001 SHALL have parameter Depth, default 1<<15, number of 32-bit words.
REQ-002 SHALL have parameter Aw, default $clog2(Depth), word address width.
REQ-003 SHALL have port clk_i  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports req_i / gnt_o  in / out  1 / 1  request and same-cycle grant.
REQ-006 SHALL have ports addr_i  in  Aw, wdata_i  in  32, strb_i  in  32 (bitwise), we_i  in  1.
REQ-007 SHALL have ports rvalid_o  out  1 and rdata_o  out  32, the response.
REQ-008 SHALL have taint inputs req_t0_i 1, addr_t0_i Aw, wdata_t0_i 32, strb_t0_i 32, we_t0_i 1.
REQ-009 SHALL have taint output rdata_t0_o  out  32, taint of rdata_o.
REQ-010 SHALL have output init_done_o  out  1, high once the taint array is cleared.

Function
REQ-011 SHALL hold a data array and a shadow taint array, each Depth x 32; the data array is not reset.
REQ-012 SHALL implement FSM INIT -> READY; INIT sweeps a counter from 0 to Depth-1, writing 0 to each taint word, one word per cycle.
REQ-013 SHALL move INIT -> READY in the cycle after the counter reaches Depth-1; READY is held until reset.
REQ-014 SHALL drive gnt_o = req_i when in READY and 0 in INIT; requests in INIT are left ungranted and are not lost to the requester.
REQ-015 SHALL assert rvalid_o for exactly one cycle, one cycle after each grant, for both reads and writes.
REQ-016 SHALL on a granted write update only data bits where strb_i is 1.
REQ-017 SHALL on a granted write set taint bit i to wdata_t0_i[i] where strb_i[i]=1, and OR in strb_t0_i[i] for every bit i.
REQ-018 SHALL on a granted write with |addr_t0_i or we_t0_i or req_t0_i set all 32 taint bits of the addressed word to 1.
REQ-019 SHALL on a granted read register rdata_o and the taint word, with rdata_t0_o = taint word OR {32{|addr_t0_i or req_t0_i}}.
REQ-020 SHALL on a granted write hold rdata_o and rdata_t0_o at their previous values.
REQ-021 SHALL make a read granted in the cycle after a write to the same address return the newly written data and taint.
REQ-022 SHALL wrap addresses modulo Depth.

Reset
REQ-023 SHALL on rst_i force state INIT, counter 0, gnt_o 0, rvalid_o 0, rdata_o 0, rdata_t0_o 0 and init_done_o 0.
REQ-024 SHALL on reset during READY or mid-sweep restart the full sweep from address 0 and drop any pending response.

Configuration
REQ-025 SHALL with macro CELLIFT_MEM_TAINT_INJECT_EN defined add inputs inj_valid_i 1, inj_addr_i Aw and inj_mask_i 32.
REQ-026 SHALL with the macro defined, in READY, OR inj_mask_i into the taint word at inj_addr_i when inj_valid_i is high.
REQ-027 SHALL when a granted write targets the same address in the same cycle, apply the write first, then OR in the mask.
REQ-028 SHALL ignore injection requests made during INIT.
REQ-029 SHALL without the macro omit the injection ports and logic entirely, with no other behavioural difference.

Verification
REQ-030 SHALL cover reset with Depth=16: req_i=1 held -> gnt_o=0 for 16 sweep cycles, then init_done_o=1 and gnt_o=1.
REQ-031 SHALL cover write then read: write addr 5, wdata 0xDEADBEEF, strb 0xFFFF0000, wdata_t0 0x000F0000 over old 0x12345678 -> next-cycle read gives rdata 0xDEAD5678, rdata_t0 0x000F0000.
REQ-032 SHALL cover a tainted address: read addr 3 with addr_t0_i=1 -> rdata_t0_o=0xFFFFFFFF; the same read with addr_t0_i=0 -> 0x00000000.
REQ-033 SHALL cover reset mid-sweep: rst_i pulsed at counter 7 -> sweep restarts at 0, rvalid_o stays 0 until READY plus a grant.
REQ-034 SHALL cover injection with the macro defined: inj_mask 0x1 at addr 9, plus a same-cycle write with wdata_t0 0x100 -> read addr 9 gives rdata_t0 0x101.
